// File: rtl/odd_even_stream_sorter.sv
// Streaming odd-even transposition sorter: loads N W-bit values, sorts them in
// N compare-exchange phases (one per cycle), then streams the ordered frame out.
module odd_even_stream_sorter #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  odx_q, odx_d;
  logic [CW-1:0]  phase_q, phase_d;
  logic [1:0]     mode_q, mode_d;
  logic [W-1:0]   mem_q [N];
  logic [W-1:0]   mem_d [N];

  // True when a must come before b under the given order; equal keys never precede.
  function automatic logic precedes(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] m);
    logic r;
    r = 1'b0;
    case (m)
      2'd0: r = (a < b);
      2'd1: r = (a > b);
      2'd2: begin
        if (a[0] != b[0])  r = a[0];
        else if (a[0])     r = (a < b);
        else               r = (a > b);
      end
      default: begin
        if (a[0] != b[0])  r = ~a[0];
        else if (!a[0])    r = (a < b);
        else               r = (a > b);
      end
    endcase
    return r;
  endfunction

  // Next-state, counter and buffer update logic for LOAD / SORT / DRAIN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    odx_d   = odx_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
          if (idx_q == '0) mode_d = mode;
          if (idx_q == LAST) begin
            idx_d   = '0;
            phase_d = '0;
            state_d = S_SORT;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      S_SORT: begin
        // Pairs start at even indices on even phases, odd indices on odd phases;
        // pairs never overlap within a phase, so in-place swaps are independent.
        for (int unsigned i = 0; i + 1 < N; i++) begin
          if (i[0] == phase_q[0]) begin
            if (precedes(mem_q[i+1], mem_q[i], mode_q)) begin
              mem_d[i]   = mem_q[i+1];
              mem_d[i+1] = mem_q[i];
            end
          end
        end
        if (phase_q == LAST) begin
          odx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (odx_q == LAST) begin
            odx_d   = '0;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            odx_d = odx_q + CW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control registers with synchronous reset back to an empty LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      odx_q   <= '0;
      phase_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      odx_q   <= odx_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  // Frame buffer; contents are don't-care until a frame has been loaded.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    out_last  = (state_q == S_DRAIN) && (odx_q == LAST);
    busy      = (state_q != S_LOAD);
    out_data  = (state_q == S_DRAIN) ? mem_q[odx_q] : '0;
  end

endmodule

// File: tb/tb_odd_even_stream_sorter.sv
// Directed bench for odd_even_stream_sorter: three instances (N=10/W=4,
// N=2/W=8, N=7/W=5) share one stimulus/response path selected by sel.
module tb_odd_even_stream_sorter;

  typedef int q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int unsigned sel;
  int          cur_n;
  logic [1:0]  mode;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy;
  logic [15:0] out_data;

  logic       iv_a, ir_a, ov_a, or_a, ol_a, bz_a;
  logic [3:0] od_a;
  logic       iv_b, ir_b, ov_b, or_b, ol_b, bz_b;
  logic [7:0] od_b;
  logic       iv_c, ir_c, ov_c, or_c, ol_c, bz_c;
  logic [4:0] od_c;

  int total = 0;
  int bad   = 0;

  assign iv_a = in_valid  && (sel == 0);
  assign or_a = out_ready && (sel == 0);
  assign iv_b = in_valid  && (sel == 1);
  assign or_b = out_ready && (sel == 1);
  assign iv_c = in_valid  && (sel == 2);
  assign or_c = out_ready && (sel == 2);

  odd_even_stream_sorter #(.W(4), .N(10)) u_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv_a), .in_data(in_data[3:0]),
    .in_ready(ir_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .out_last(ol_a), .busy(bz_a));

  odd_even_stream_sorter #(.W(8), .N(2)) u_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv_b), .in_data(in_data[7:0]),
    .in_ready(ir_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .out_last(ol_b), .busy(bz_b));

  odd_even_stream_sorter #(.W(5), .N(7)) u_c (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv_c), .in_data(in_data[4:0]),
    .in_ready(ir_c), .out_valid(ov_c), .out_ready(or_c), .out_data(od_c),
    .out_last(ol_c), .busy(bz_c));

  always_comb begin
    case (sel)
      1: begin
        in_ready = ir_b; out_valid = ov_b; out_last = ol_b; busy = bz_b;
        out_data = {8'b0, od_b};
      end
      2: begin
        in_ready = ir_c; out_valid = ov_c; out_last = ol_c; busy = bz_c;
        out_data = {11'b0, od_c};
      end
      default: begin
        in_ready = ir_a; out_valid = ov_a; out_last = ol_a; busy = bz_a;
        out_data = {12'b0, od_a};
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit prec(input int a, input int b, input int m);
    bit ao, bo;
    ao = a[0];
    bo = b[0];
    case (m)
      0: return a < b;
      1: return a > b;
      2: begin
        if (ao != bo) return ao;
        return ao ? (a < b) : (a > b);
      end
      default: begin
        if (ao != bo) return !ao;
        return !ao ? (a < b) : (a > b);
      end
    endcase
  endfunction

  function automatic q_t ref_sort(input q_t v, input int m);
    q_t r;
    int t;
    r = v;
    for (int i = 1; i < r.size(); i++) begin
      for (int j = i; j > 0 && prec(r[j], r[j-1], m); j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    end
    return r;
  endfunction

  task automatic send_frame(input q_t vals, input logic [1:0] m0, input logic [1:0] mrest,
                            input bit gaps);
    bit hs;
    int guard;
    for (int k = 0; k < vals.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = 16'(vals[k]);
      mode     = (k == 0) ? m0 : mrest;
      guard    = 0;
      do begin
        hs = in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!hs && guard < 100);
      if (!hs) check("in_handshake_timeout", 0, 1);
    end
    in_valid = 1'b0;
    mode     = 2'd0;
  endtask

  task automatic recv_frame(input q_t exp, input int nbeats, input bit bp, input bit chk_lat);
    int  waited = 0;
    int  k = 0;
    int  ph = 0;
    int  guard = 0;
    bit  sort_ok = 1'b1;
    bit  stalled = 1'b0;
    logic [15:0] hold_d;
    logic        hold_l;
    out_ready = 1'b0;
    while (!out_valid && waited < 1000) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) sort_ok = 1'b0;
      @(posedge clk); #1;
      waited++;
    end
    check("out_valid_seen", out_valid, 1);
    check("sort_flags", sort_ok, 1);
    if (chk_lat) check("first_valid_latency", waited + 1, cur_n + 1);
    while (k < nbeats && guard < 1000) begin
      guard++;
      out_ready = bp ? (ph == 0 || ph == 3) : 1'b1;
      ph = (ph + 1) % 4;
      if (stalled) begin
        check("stall_data", out_data, hold_d);
        check("stall_last", out_last, hold_l);
      end
      if (bp) check("drain_flags", {busy, in_ready, out_valid}, 3'b101);
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        check($sformatf("beat%0d", k), out_data, exp[k]);
        check($sformatf("last%0d", k), out_last, (k == cur_n - 1));
        k++;
      end else if (out_valid) begin
        stalled = 1'b1;
        hold_d  = out_data;
        hold_l  = out_last;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (k != nbeats) check("drain_timeout", k, nbeats);
    if (nbeats == cur_n) begin
      check("in_ready_after_drain", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("idle_out_data", out_data, 0);
    end
  endtask

  task automatic reset_pulse();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
  endtask

  initial begin
    q_t f, e, fz, ez, r;
    int m;
    rst = 1'b1; sel = 0; cur_n = 10; mode = 2'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check($sformatf("reset_in_ready_%0d", s), in_ready, 1);
      check($sformatf("reset_out_valid_%0d", s), out_valid, 0);
      check($sformatf("reset_out_last_%0d", s), out_last, 0);
      check($sformatf("reset_out_data_%0d", s), out_data, 0);
      check($sformatf("reset_busy_%0d", s), busy, 0);
    end
    sel = 0; cur_n = 10;
    @(posedge clk); #1;

    f = '{2, 1, 6, 7, 4, 4, 9, 8, 2, 3};

    // mode 2 with latency check
    send_frame(f, 2'd2, 2'd2, 1'b0);
    e = '{1, 3, 7, 9, 8, 6, 4, 4, 2, 2};
    recv_frame(e, 10, 1'b0, 1'b1);

    send_frame(f, 2'd0, 2'd0, 1'b0);
    e = '{1, 2, 2, 3, 4, 4, 6, 7, 8, 9};
    recv_frame(e, 10, 1'b0, 1'b1);

    send_frame(f, 2'd1, 2'd1, 1'b0);
    e = '{9, 8, 7, 6, 4, 4, 3, 2, 2, 1};
    recv_frame(e, 10, 1'b0, 1'b0);

    send_frame(f, 2'd3, 2'd3, 1'b0);
    e = '{2, 2, 4, 4, 6, 8, 9, 7, 3, 1};
    recv_frame(e, 10, 1'b0, 1'b0);

    // backpressure plus input gaps
    send_frame(f, 2'd0, 2'd0, 1'b1);
    e = '{1, 2, 2, 3, 4, 4, 6, 7, 8, 9};
    recv_frame(e, 10, 1'b1, 1'b0);

    // mode sampled only on beat 0
    send_frame(f, 2'd0, 2'd1, 1'b0);
    e = '{1, 2, 2, 3, 4, 4, 6, 7, 8, 9};
    recv_frame(e, 10, 1'b0, 1'b0);
    send_frame(f, 2'd1, 2'd0, 1'b0);
    e = '{9, 8, 7, 6, 4, 4, 3, 2, 2, 1};
    recv_frame(e, 10, 1'b0, 1'b0);

    // reset during SORT
    fz = '{15, 0, 15, 0, 15, 0, 15, 0, 15, 0};
    ez = '{0, 0, 0, 0, 0, 15, 15, 15, 15, 15};
    send_frame(f, 2'd0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_pulse();
    send_frame(fz, 2'd0, 2'd0, 1'b0);
    recv_frame(ez, 10, 1'b0, 1'b1);

    // reset during DRAIN after three beats
    send_frame(f, 2'd0, 2'd0, 1'b0);
    e = '{1, 2, 2, 3, 4, 4, 6, 7, 8, 9};
    recv_frame(e, 3, 1'b0, 1'b0);
    reset_pulse();
    send_frame(fz, 2'd0, 2'd0, 1'b0);
    recv_frame(ez, 10, 1'b0, 1'b0);

    // N=2, W=8
    sel = 1; cur_n = 2; #1;
    f = '{200, 5};
    for (int mm = 0; mm < 4; mm++) begin
      send_frame(f, 2'(mm), 2'(mm), 1'b0);
      if (mm == 0 || mm == 2) e = '{5, 200};
      else                    e = '{200, 5};
      recv_frame(e, 2, 1'b0, 1'b1);
    end

    // N=7, W=5 random frames against the reference model
    sel = 2; cur_n = 7; #1;
    for (int fr = 0; fr < 6; fr++) begin
      r = {};
      for (int i = 0; i < 7; i++) r.push_back(int'($urandom_range(0, 31)));
      m = (fr < 4) ? fr : int'($urandom_range(0, 3));
      send_frame(r, 2'(m), 2'($urandom_range(0, 3)), fr[0]);
      e = ref_sort(r, m);
      recv_frame(e, 7, fr[0], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_even_stream_sorter.md
# odd_even_stream_sorter

Parametrised, clocked successor to the combinational 10×4-bit odd/even sorter. Accepts a frame of N unsigned W-bit values over a valid/ready stream and sorts it in place with an odd-even transposition network, one compare-exchange phase per cycle. It then streams the ordered frame out over a second valid/ready stream. A per-frame mode selects plain ascending, plain descending, or one of the two parity-grouped orders.

## Interface
- W, 4: element width in bits, 2..16.
- N, 10: elements per frame, 2..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  order select, sampled on the first accepted input beat of a frame.
- in_valid  in  1  input beat valid.
- in_data  in  W  input element.
- in_ready  out  1  block accepts an input beat.
- out_valid  out  1  output beat valid.
- out_data  out  W  output element.
- out_last  out  1  marks beat N-1 of the output frame.
- busy  out  1  high in the SORT and DRAIN states.

## Operation
- There are three states: LOAD, SORT, DRAIN.
  - Reset enters LOAD with load/drain counters cleared.
- **LOAD**
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data to buf[idx] and increments idx.
  - Beat 0 latches mode into mode_r.
  - The handshake with idx=N-1 moves the block to SORT and clears the phase counter.
- **SORT**
  - in_ready=0. Runs exactly N cycles.
  - Phase p even: compare-exchange pairs (0,1),(2,3),…
  - Phase p odd: compare-exchange pairs (1,2),(3,4),…
  - With odd N, the unpaired end element is held.
  - After phase N-1 the block moves to DRAIN.
- **Ordering rule**: "a precedes b" is defined per mode_r. A pair (buf[i], buf[i+1]) is swapped iff buf[i+1] strictly precedes buf[i]. Equal keys are never swapped.
  - 0: a<b (ascending).
  - 1: a>b (descending).
  - 2: odd before even; odd group ascending, even group descending.
  - 3: even before odd; even group ascending, odd group descending.
- **DRAIN**
  - out_valid=1, out_data=buf[odx], out_last=(odx==N-1).
  - Each handshake (out_valid & out_ready) increments odx.
  - The handshake with odx=N-1 moves the block to LOAD and clears idx/odx.
- Arithmetic is unsigned and parity is bit 0. All compares are W bits wide, with no extension.
- in_valid, in_data and mode are ignored outside LOAD. mode is ignored on LOAD beats 1..N-1.

## Timing
- After reset (rst low from cycle r), outputs are: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
- The last input handshake occurs at cycle t. SORT phases run at t+1..t+N. out_valid first rises at t+N+1.
- With out_ready held high, output beat k is transferred at t+N+1+k. in_ready rises one cycle after the final output handshake.
- Minimum frame period is 3N cycles; input and output frames never overlap.
- **Backpressure**: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- out_data is registered (buf read via odx register). It is 0 outside DRAIN.
- in_valid gaps in LOAD stall idx, with no timeout.
- rst high in any state, mid-frame included, returns the block to LOAD on the next edge. The partial frame is discarded and all outputs revert to reset values. Buffer contents need not be cleared.

## Test plan
- **Mode 2**: mode=2, frame 2,1,6,7,4,4,9,8,2,3 (W=4, N=10), out_ready=1.
  - Output is 1,3,7,9,8,6,4,4,2,2.
  - out_last only on the final 2.
  - First out_valid exactly 11 cycles after the last input handshake.
- **Modes 0, 1, 3**: same frame in each mode.
  - mode 0 → 1,2,2,3,4,4,6,7,8,9.
  - mode 1 → 9,8,7,6,4,4,3,2,2,1.
  - mode 3 → 2,2,4,4,6,8,9,7,3,1.
- **Backpressure**: mode 0; out_ready toggles 1,0,0,1 repeatedly, and in_valid has random gaps.
  - Output still 1,2,2,3,4,4,6,7,8,9.
  - out_data stable while stalled.
  - in_ready=0 throughout SORT/DRAIN.
- **Mode sampling**: mode changes from 0 to 1 after beat 0.
  - Frame sorts ascending (mode 0).
  - Next frame, with mode=1 at its beat 0, sorts descending.
- **Mid-operation reset**: rst pulse during SORT, and separately during DRAIN after 3 output beats.
  - Next cycle: in_ready=1, out_valid=0, busy=0.
  - A fresh frame 15,0,15,0,… (mode 0) outputs five 0s then five 15s.
- **Edge parameters**: N=2, W=8, inputs 200,5.
  - mode 0 → 5,200; mode 1 → 200,5.
  - mode 2 → 5,200 (odd first); mode 3 → 200,5.
  - Run with N=7 random frames checked against a reference sort model.
